// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake status, word type, and the memory arbiter FSM states.
package cpu_types_pkg;

  localparam int WORD_W = 32;
  localparam int WDOG_W = 8;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DACC = 2'b01,
    IACC = 2'b10,
    DONE = 2'b11
  } arb_state_t;

endpackage

// File: rtl/mem_watchdog.sv
// Saturating access-duration counter; expired is high once TIMEOUT cycles have been counted.
module mem_watchdog
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(TIMEOUT);

  logic [WDOG_W-1:0] count_reg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != LIMIT)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = (count_reg == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data beats instruction, no preemption, registered hits/loads,
// and a watchdog that turns a hung RAM access into a completed, faulted transaction.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              imemREN,
  input  logic [ADDR_W-1:0] imemaddr,
  output logic              ihit,
  output logic [DATA_W-1:0] imemload,
  input  logic              dmemREN,
  input  logic              dmemWEN,
  input  logic [ADDR_W-1:0] dmemaddr,
  input  logic [DATA_W-1:0] dmemstore,
  output logic              dhit,
  output logic [DATA_W-1:0] dmemload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              fault
);

  arb_state_t        state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] store_reg, store_next;
  logic [DATA_W-1:0] iload_reg, iload_next;
  logic [DATA_W-1:0] dload_reg, dload_next;
  logic              write_reg, write_next;
  logic              fault_reg, fault_next;
  logic              ihit_reg, ihit_next;
  logic              dhit_reg, dhit_next;

  ramstate_t ram_st;
  logic      in_access;
  logic      wd_clear;
  logic      wd_expired;
  logic      exit_ok;
  logic      exit_bad;

  assign ram_st    = ramstate_t'(ramstate);
  assign in_access = (state_reg == DACC) || (state_reg == IACC);
  // A real ACCESS wins over a watchdog expiry seen in the same cycle.
  assign exit_ok   = in_access && (ram_st == ACCESS);
  assign exit_bad  = in_access && !exit_ok && ((ram_st == ERROR) || wd_expired);

  mem_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .CLK    (CLK),
    .RST    (RST),
    .clear  (wd_clear),
    .enable (in_access),
    .expired(wd_expired)
  );

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    store_next = store_reg;
    iload_next = iload_reg;
    dload_next = dload_reg;
    write_next = write_reg;
    fault_next = fault_reg;
    ihit_next  = 1'b0;
    dhit_next  = 1'b0;
    wd_clear   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (dmemREN || dmemWEN) begin
          addr_next  = dmemaddr;
          store_next = dmemstore;
          write_next = dmemWEN;
          wd_clear   = 1'b1;
          state_next = DACC;
          if (dmemREN && dmemWEN) begin
            fault_next = 1'b1;
          end
        end else if (imemREN) begin
          addr_next  = imemaddr;
          write_next = 1'b0;
          wd_clear   = 1'b1;
          state_next = IACC;
        end
      end
      DACC, IACC: begin
        if (exit_ok || exit_bad) begin
          state_next = DONE;
          if (state_reg == DACC) begin
            dload_next = exit_ok ? ramload : '1;
            dhit_next  = 1'b1;
          end else begin
            iload_next = exit_ok ? ramload : '1;
            ihit_next  = 1'b1;
          end
          if (exit_bad) begin
            fault_next = 1'b1;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      store_reg <= '0;
      iload_reg <= '0;
      dload_reg <= '0;
      write_reg <= 1'b0;
      fault_reg <= 1'b0;
      ihit_reg  <= 1'b0;
      dhit_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      store_reg <= store_next;
      iload_reg <= iload_next;
      dload_reg <= dload_next;
      write_reg <= write_next;
      fault_reg <= fault_next;
      ihit_reg  <= ihit_next;
      dhit_reg  <= dhit_next;
    end
  end

  // write_reg is cleared on instruction grants, so it alone selects the strobe.
  assign ramREN   = in_access && !write_reg;
  assign ramWEN   = (state_reg == DACC) && write_reg;
  assign ramaddr  = addr_reg;
  assign ramstore = store_reg;
  assign ihit     = ihit_reg;
  assign dhit     = dhit_reg;
  assign imemload = iload_reg;
  assign dmemload = dload_reg;
  assign fault    = fault_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of transactions against a small RAM responder,
// plus hand-written reset and mid-access reset sequences.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        dhit;
  logic [31:0] dmemload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        fault;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  mem_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(8)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .dmemREN  (dmemREN),
    .dmemWEN  (dmemWEN),
    .dmemaddr (dmemaddr),
    .dmemstore(dmemstore),
    .dhit     (dhit),
    .dmemload (dmemload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate),
    .fault    (fault)
  );

  typedef struct {
    logic        pre_rst;
    logic        iren;
    logic        dren;
    logic        dwen;
    logic [31:0] iaddr;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] iload;
    logic [31:0] dload;
    int          i_busy;
    int          d_busy;
    logic        i_err;
    logic        d_err;
    int          drop_cyc;
    int          exp_icyc;
    int          exp_dcyc;
    logic [31:0] exp_iload;
    logic [31:0] exp_dload;
    logic        exp_ren;
    logic        exp_wen;
    logic [31:0] exp_addr;
    logic [31:0] exp_store;
    int          exp_acc;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drop_requests();
    imemREN   = 1'b0;
    dmemREN   = 1'b0;
    dmemWEN   = 1'b0;
    imemaddr  = '0;
    dmemaddr  = '0;
    dmemstore = '0;
  endtask

  task automatic do_reset();
    RST      = 1'b1;
    ramstate = FREE;
    ramload  = '0;
    drop_requests();
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  // Applies one transaction just after a rising edge and plays the RAM for 16 cycles.
  // Cycle numbers are counted from the edge that samples the request (that edge ends cycle 0).
  task automatic run_vec(input int idx, input vec_t v);
    int          ih_n, dh_n, ih_c, dh_c, acc, busy_left;
    logic        prev_strobe, dpend, f_ren, f_wen;
    logic [31:0] ih_v, dh_v, f_addr, f_store;
    if (v.pre_rst) do_reset();
    ih_n = 0; dh_n = 0; ih_c = -1; dh_c = -1; acc = 0;
    ih_v = '0; dh_v = '0; f_ren = 1'b0; f_wen = 1'b0; f_addr = '0; f_store = '0;
    prev_strobe = 1'b0;
    dpend     = v.dren | v.dwen;
    busy_left = dpend ? v.d_busy : v.i_busy;
    imemREN   = v.iren;
    imemaddr  = v.iaddr;
    dmemREN   = v.dren;
    dmemWEN   = v.dwen;
    dmemaddr  = v.daddr;
    dmemstore = v.dstore;
    ramstate  = FREE;
    for (int c = 1; c <= 16; c++) begin
      @(negedge CLK);
      if (c == v.drop_cyc) begin
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
      end
      if ((ramREN || ramWEN) && !prev_strobe) begin
        acc++;
        if (acc == 1) begin
          f_ren = ramREN; f_wen = ramWEN; f_addr = ramaddr; f_store = ramstore;
        end
      end
      prev_strobe = ramREN || ramWEN;
      if (dhit) begin
        dh_n++; dh_c = c - 1; dh_v = dmemload;
        dmemREN = 1'b0; dmemWEN = 1'b0; dpend = 1'b0;
      end
      if (ihit) begin
        ih_n++; ih_c = c - 1; ih_v = imemload;
        imemREN = 1'b0;
      end
      if (ramREN || ramWEN) begin
        ramload = dpend ? v.dload : v.iload;
        if (busy_left > 0) begin
          ramstate = BUSY;
          busy_left--;
        end else begin
          ramstate = (dpend ? v.d_err : v.i_err) ? ERROR : ACCESS;
        end
      end else begin
        ramstate  = FREE;
        busy_left = dpend ? v.d_busy : v.i_busy;
      end
    end
    if (v.exp_dcyc > 0) begin
      check($sformatf("v%0d dhit_count", idx), 64'(dh_n), 64'd1);
      check($sformatf("v%0d dhit_cycle", idx), 64'(dh_c), 64'(v.exp_dcyc));
      check($sformatf("v%0d dmemload", idx), 64'(dh_v), 64'(v.exp_dload));
    end else begin
      check($sformatf("v%0d dhit_count", idx), 64'(dh_n), 64'd0);
    end
    if (v.exp_icyc > 0) begin
      check($sformatf("v%0d ihit_count", idx), 64'(ih_n), 64'd1);
      check($sformatf("v%0d ihit_cycle", idx), 64'(ih_c), 64'(v.exp_icyc));
      check($sformatf("v%0d imemload", idx), 64'(ih_v), 64'(v.exp_iload));
    end else begin
      check($sformatf("v%0d ihit_count", idx), 64'(ih_n), 64'd0);
    end
    check($sformatf("v%0d accesses", idx), 64'(acc), 64'(v.exp_acc));
    check($sformatf("v%0d first_strobes", idx), 64'({f_ren, f_wen}), 64'({v.exp_ren, v.exp_wen}));
    check($sformatf("v%0d first_ramaddr", idx), 64'(f_addr), 64'(v.exp_addr));
    if (v.exp_wen) check($sformatf("v%0d first_ramstore", idx), 64'(f_store), 64'(v.exp_store));
    check($sformatf("v%0d fault", idx), 64'(fault), 64'(v.exp_fault));
    $display("txn %0d: dhit@%0d dload=%08h ihit@%0d iload=%08h accesses=%0d fault=%0b",
             idx, dh_c, dh_v, ih_c, ih_v, acc, fault);
    ramstate = FREE;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    vec_t fresh;

    //          rst   iren  dren  dwen  iaddr        daddr        dstore        iload         dload         ib db  ierr  derr  drop icyc dcyc exp_iload     exp_dload     ren   wen   addr         store         acc fault
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h40,      32'h0,       32'h0,        32'h8C220004, 32'h0,        0, 0,   1'b0, 1'b0, 0,   2,   0,   32'h8C220004, 32'h0,        1'b1, 1'b0, 32'h40,      32'h0,        1, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,       32'h200,     32'h0,        32'h0,        32'h12345678, 0, 1,   1'b0, 1'b0, 0,   0,   3,   32'h0,        32'h12345678, 1'b1, 1'b0, 32'h200,     32'h0,        1, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h80,      32'h100,     32'hDEADBEEF, 32'hCAFEF00D, 32'h0,        0, 3,   1'b0, 1'b0, 0,   8,   5,   32'hCAFEF00D, 32'h0,        1'b0, 1'b1, 32'h100,     32'hDEADBEEF, 2, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,       32'h104,     32'h0BADF00D, 32'h0,        32'hA5A5A5A5, 0, 0,   1'b0, 1'b0, 0,   0,   2,   32'h0,        32'hA5A5A5A5, 1'b0, 1'b1, 32'h104,     32'h0BADF00D, 1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h44,      32'h0,       32'h0,        32'h11112222, 32'h0,        2, 0,   1'b0, 1'b0, 0,   4,   0,   32'h11112222, 32'h0,        1'b1, 1'b0, 32'h44,      32'h0,        1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,       32'h600,     32'h0,        32'h0,        32'h0F0F0F0F, 0, 1,   1'b0, 1'b0, 2,   0,   3,   32'h0,        32'h0F0F0F0F, 1'b1, 1'b0, 32'h600,     32'h0,        1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h0,       32'h300,     32'h55AA55AA, 32'h0,        32'h0,        0, 0,   1'b0, 1'b0, 0,   0,   2,   32'h0,        32'h0,        1'b0, 1'b1, 32'h300,     32'h55AA55AA, 1, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,       32'h400,     32'h0,        32'h0,        32'h13579BDF, 0, 200, 1'b0, 1'b0, 0,   0,   10,  32'h0,        32'hFFFFFFFF, 1'b1, 1'b0, 32'h400,     32'h0,        1, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h48,      32'h0,       32'h0,        32'h01020304, 32'h0,        0, 0,   1'b0, 1'b0, 0,   2,   0,   32'h01020304, 32'h0,        1'b1, 1'b0, 32'h48,      32'h0,        1, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,       32'h410,     32'h0,        32'h0,        32'h24682468, 0, 0,   1'b0, 1'b1, 0,   0,   2,   32'h0,        32'hFFFFFFFF, 1'b1, 1'b0, 32'h410,     32'h0,        1, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h4C,      32'h0,       32'h0,        32'h9999AAAA, 32'h0,        200, 0, 1'b0, 1'b0, 0,   10,  0,   32'hFFFFFFFF, 32'h0,        1'b1, 1'b0, 32'h4C,      32'h0,        1, 1'b1};

    RST      = 1'b1;
    ramstate = FREE;
    ramload  = '0;
    drop_requests();
    #1;
    check("reset_ctrl", 64'({ihit, dhit, ramREN, ramWEN, fault}), 64'd0);
    check("reset_ram_bus", {ramaddr, ramstore}, 64'd0);
    check("reset_loads", {imemload, dmemload}, 64'd0);
    @(posedge CLK);
    #1 RST = 1'b0;
    @(posedge CLK);
    #1;
    $display("reset released");

    for (int i = 0; i < 11; i++) begin
      run_vec(i, vecs[i]);
    end

    // Asynchronous reset while a write is in flight.
    dmemWEN   = 1'b1;
    dmemaddr  = 32'h500;
    dmemstore = 32'h00000077;
    ramstate  = FREE;
    @(negedge CLK);
    ramstate = BUSY;
    @(negedge CLK);
    check("midrst_wen_before", 64'({ramWEN, ramREN}), 64'b10);
    check("midrst_addr_before", 64'(ramaddr), 64'h500);
    #2 RST = 1'b1;
    #1;
    check("midrst_ctrl", 64'({ihit, dhit, ramREN, ramWEN, fault}), 64'd0);
    check("midrst_ram_bus", {ramaddr, ramstore}, 64'd0);
    check("midrst_loads", {imemload, dmemload}, 64'd0);
    $display("reset asserted mid-access: ramWEN=%0b ramaddr=%08h fault=%0b", ramWEN, ramaddr, fault);
    drop_requests();
    ramstate = FREE;
    @(posedge CLK);
    #1 RST = 1'b0;
    @(posedge CLK);
    #1;

    fresh = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h60, 32'h0, 32'h0, 32'h3C010040, 32'h0, 0, 0,
              1'b0, 1'b0, 0, 2, 0, 32'h3C010040, 32'h0, 1'b1, 1'b0, 32'h60, 32'h0, 1, 1'b0};
    run_vec(11, fresh);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the instruction-fetch and data-access streams produced by the request unit and datapath onto the single-port system RAM. It sits directly downstream of the request unit. It grants one access at a time, with data having priority over instruction. It tracks the RAM's variable-latency handshake and returns one-cycle `ihit`/`dhit` pulses with registered load data. A watchdog converts a hung RAM access into a completed, faulted transaction so the pipeline never deadlocks.

## Interface
Parameters:
- `ADDR_W`, 32, address width in bits.
- `DATA_W`, 32, data word width in bits.
- `TIMEOUT`, 64, maximum cycles spent in an access state before the watchdog forces completion; legal range 2–255.

Ports:
- `CLK`  in  1  system clock; all state changes on the rising edge.
- `RST`  in  1  reset; asynchronous and active-high.
- `imemREN`  in  1  instruction read request; held by the requester until `ihit`.
- `imemaddr`  in  ADDR_W  instruction address.
- `ihit`  out  1  one-cycle pulse when the instruction access completes.
- `imemload`  out  DATA_W  registered instruction word; valid while `ihit` is high.
- `dmemREN`  in  1  data read request; held by the requester until `dhit`.
- `dmemWEN`  in  1  data write request; held by the requester until `dhit`.
- `dmemaddr`  in  ADDR_W  data address.
- `dmemstore`  in  DATA_W  store data.
- `dhit`  out  1  one-cycle pulse when the data access completes.
- `dmemload`  out  DATA_W  registered load word; valid while `dhit` is high.
- `ramREN`  out  1  RAM read strobe.
- `ramWEN`  out  1  RAM write strobe.
- `ramaddr`  out  ADDR_W  RAM address.
- `ramstore`  out  DATA_W  RAM write data.
- `ramload`  in  DATA_W  RAM read data; sampled in the cycle `ramstate` is ACCESS.
- `ramstate`  in  2  RAM status (`ramstate_t`): FREE, BUSY, ACCESS, ERROR.
- `fault`  out  1  sticky flag: RAM ERROR, watchdog expiry, or `dmemREN`&`dmemWEN` both high at grant; cleared only by `RST`.

## Operation
FSM states: IDLE, DACC, IACC, DONE.
- IDLE:
  - If `dmemREN|dmemWEN`, latch address, store data, and operation, then go to DACC. The operation is a write if `dmemWEN` is high.
  - Otherwise, if `imemREN`, latch `imemaddr`, then go to IACC.
  - Otherwise stay in IDLE.
- DACC/IACC:
  - `ramaddr`/`ramstore` are driven from the latched registers.
  - `ramREN`/`ramWEN` are driven from the latched operation.
  - The RAM strobes are zero in every other state.
- DACC/IACC exit:
  - On `ramstate==ACCESS`, capture `ramload` into the owner's load register and go to DONE.
  - On `ramstate==ERROR`, or when the watchdog count reaches TIMEOUT, go to DONE. The load register is set to all-ones and `fault` is set.
- DONE: pulse the owner's hit for exactly one cycle, then go to IDLE.
- Arbitration:
  - Data always wins a same-cycle tie.
  - No preemption: a granted access always completes.
- Request withdrawal: if a requester drops its request while its access is in flight, the access still completes and the hit still pulses.
- Both `dmemREN` and `dmemWEN` high at grant: the access is performed as a write and `fault` is set.
- Watchdog:
  - 8-bit counter, cleared on entry to DACC/IACC.
  - Increments each cycle in DACC/IACC.
  - Saturates at TIMEOUT.
- Reset, including mid-access:
  - State returns to IDLE.
  - `ihit`, `dhit`, `ramREN`, `ramWEN`, and `fault` are 0.
  - `ramaddr`, `ramstore`, `imemload`, `dmemload`, and the watchdog are 0.
  - The in-flight access is abandoned.

## Timing
- Requests are sampled in IDLE at edge N.
- RAM strobes are asserted during cycle N+1 onward.
- If ACCESS is seen in cycle N+1, the hit is high in cycle N+2. Minimum request-to-hit latency is 2 cycles.
- Each RAM BUSY cycle adds one cycle of latency.
- Back-to-back accesses: IDLE lasts 1 cycle between accesses, so the minimum spacing between hits of consecutive accesses is 3 cycles.
- Hit and load outputs come from registers; there is no combinational path from `ramstate` to `ihit`/`dhit`.
- A hung access produces `fault` and the hit in cycle N+1+TIMEOUT+1.

## Structure
- `ramstate_t`, `word_t`, and the FSM state enum belong in the shared `cpu_types_pkg`. The package already carries the RAM types.
- One sub-module, `mem_watchdog`:
  - Inputs: `CLK`, `RST`, clear, and enable.
  - Output: `expired`.
  - Parameterised by TIMEOUT.
- Everything else stays in `mem_arbiter`.

## Test plan
- Instruction read only, RAM returns ACCESS immediately with `ramload=0x8C220004`, `imemaddr=0x40` -> `ramREN` high 1 cycle with `ramaddr=0x40`; `ihit` high at cycle 2 with `imemload=0x8C220004`; `dhit` stays 0.
- `imemREN` and `dmemWEN` asserted together, `dmemaddr=0x100`, `dmemstore=0xDEADBEEF`, RAM BUSY 3 cycles -> data is served first (`ramWEN`, `ramstore=0xDEADBEEF`), `dhit` at cycle 5; then the instruction read, with `ihit` 3 cycles later.
- `dmemREN` with RAM held BUSY, TIMEOUT=8 -> `dhit` pulses at cycle 10, `dmemload=0xFFFFFFFF`, `fault`=1 and remains set through later clean accesses.
- `RST` asserted while in DACC with `ramWEN` high -> all outputs 0 asynchronously; after release, a fresh `imemREN` completes normally with a 2-cycle latency.
- `dmemREN` dropped one cycle after grant, RAM ACCESS on the 2nd access cycle -> `dhit` still pulses once; no second access is issued.
- `dmemREN`=`dmemWEN`=1 at grant -> `ramWEN`=1, `ramREN`=0, `fault`=1.
